// File: rtl/gat_pkg.sv
// Shared definitions for the GAT convolution layer readout path.
//
// gat_define : default layer geometry (node count, features per node,
//              new-feature BRAM depth).
// gat_pkg    : readout FSM state type and the row-pack helper used by the
//              row buffers. The new-feature depth comes from gat_define.
//
// No ports; packages only.

package gat_define;
    localparam int unsigned NUM_SUBGRAPHS     = 2708;
    localparam int unsigned NUM_FEATURE_OUT   = 16;
    localparam int unsigned NEW_FEATURE_DEPTH = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
endpackage

package gat_pkg;
    localparam int unsigned GAT_NUM_SUBGRAPHS     = gat_define::NUM_SUBGRAPHS;
    localparam int unsigned GAT_NUM_FEATURE_OUT   = gat_define::NUM_FEATURE_OUT;
    localparam int unsigned GAT_NEW_FEATURE_DEPTH = gat_define::NEW_FEATURE_DEPTH;

    // Upper bounds for the width-agnostic pack helper.
    localparam int unsigned ROW_MAX_W  = 1024;
    localparam int unsigned ELEM_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } feat_state_e;

    // Writes elem (low elem_w bits) into slot idx of a packed row, leaving
    // all other slots untouched. Callers cast to/from the bound widths.
    function automatic logic [ROW_MAX_W-1:0] row_insert(
        input logic [ROW_MAX_W-1:0]  row,
        input logic [ELEM_MAX_W-1:0] elem,
        input int unsigned           idx,
        input int unsigned           elem_w
    );
        logic [ROW_MAX_W-1:0] field_mask;
        logic [ROW_MAX_W-1:0] field;
        field_mask = ((ROW_MAX_W'(1) << elem_w) - ROW_MAX_W'(1)) << (idx * elem_w);
        field      = (ROW_MAX_W'(elem) << (idx * elem_w)) & field_mask;
        return (row & ~field_mask) | field;
    endfunction
endpackage

// File: rtl/feat_row_buffer.sv
// One row of the ping-pong pair in feat_stream_out.
// Collects NUM_FEATURE_OUT returned elements into a packed row and raises
// full_o once the last element lands; clr_i (handshake) releases it.
// Optional macro FEAT_ARGMAX_EN adds a running signed max and class_o.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   wr_en_i    write one element this cycle
//   wr_idx_i   element slot being written
//   wr_data_i  element value (signed)
//   clr_i      row consumed; drop full flag
//   full_o     row complete
//   row_o      packed row, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   class_o    index of the largest element, lowest on ties (FEAT_ARGMAX_EN)

module feat_row_buffer
    import gat_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned NUM_FEATURE_OUT = 16,
    localparam int unsigned ELEM_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1,
    localparam int unsigned ROW_W  = DATA_WIDTH * NUM_FEATURE_OUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ELEM_W-1:0]     wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  clr_i,
    output logic                  full_o,
    output logic [ROW_W-1:0]      row_o
`ifdef FEAT_ARGMAX_EN
    ,
    output logic [ELEM_W-1:0]     class_o
`endif
);

    logic [ROW_W-1:0] row_q, row_d;
    logic             full_q, full_d;
    logic             wr_last;

    assign wr_last = (wr_idx_i == ELEM_W'(NUM_FEATURE_OUT - 1));

    always_comb begin
        row_d  = row_q;
        full_d = full_q;
        if (wr_en_i) begin
            row_d = ROW_W'(row_insert(ROW_MAX_W'(row_q), ELEM_MAX_W'(wr_data_i),
                                      32'(wr_idx_i), DATA_WIDTH));
            if (wr_last) full_d = 1'b1;
        end
        if (clr_i) full_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            full_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            full_q <= full_d;
        end
    end

    assign full_o = full_q;
    assign row_o  = row_q;

`ifdef FEAT_ARGMAX_EN
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [ELEM_W-1:0]     class_q, class_d;

    // Element 0 seeds the max; strict compare keeps the lowest index on ties.
    always_comb begin
        max_d   = max_q;
        class_d = class_q;
        if (wr_en_i && ((wr_idx_i == '0) || ($signed(wr_data_i) > $signed(max_q)))) begin
            max_d   = wr_data_i;
            class_d = wr_idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q   <= '0;
            class_q <= '0;
        end else begin
            max_q   <= max_d;
            class_q <= class_d;
        end
    end

    assign class_o = class_q;
`endif

endmodule

// File: rtl/feat_stream_out.sv
// Readout engine for the GAT new-feature BRAM. On start_i it reads every
// node's NUM_FEATURE_OUT features through the BRAM read port, packs them
// into one beat per node and streams the beats out on valid/ready.
// Optional macro FEAT_ARGMAX_EN adds m_class_o (argmax of each beat).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i           start pulse (ignored while busy_o)
//   busy_o            run in progress
//   done_o            one-cycle pulse after the last beat handshake
//   feat_bram_addrb   BRAM read address
//   feat_bram_dout    BRAM read data, BRAM_LATENCY cycles after address
//   m_data_o          packed beat, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   m_node_o          node index of the beat
//   m_valid_o         beat valid
//   m_ready_i         sink ready
//   m_last_o          beat is the last node
//   m_class_o         argmax index of the beat (FEAT_ARGMAX_EN)

module feat_stream_out
    import gat_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned NUM_SUBGRAPHS   = GAT_NUM_SUBGRAPHS,
    parameter int unsigned NUM_FEATURE_OUT = GAT_NUM_FEATURE_OUT,
    parameter int unsigned BRAM_LATENCY    = 2,
    localparam int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    localparam int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    localparam int unsigned NODE_IDX_W         = $clog2(NUM_SUBGRAPHS),
    localparam int unsigned ELEM_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1,
    localparam int unsigned ROW_W  = DATA_WIDTH * NUM_FEATURE_OUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
    input  logic [DATA_WIDTH-1:0]         feat_bram_dout,
    output logic [ROW_W-1:0]              m_data_o,
    output logic [NODE_IDX_W-1:0]         m_node_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          m_last_o
`ifdef FEAT_ARGMAX_EN
    ,
    output logic [ELEM_W-1:0]             m_class_o
`endif
);

    feat_state_e state_q, state_d;

    logic [NEW_FEATURE_ADDR_W-1:0] addr_q, addr_d, next_addr_q, next_addr_d;
    logic [ELEM_W-1:0]             elem_cnt_q, elem_cnt_d;
    logic [NODE_IDX_W-1:0]         row_cnt_q, row_cnt_d, send_node_q, send_node_d;
    logic                          iss_buf_q, iss_buf_d;
    logic                          ret_buf_q, ret_buf_d;
    logic                          send_buf_q, send_buf_d;
    logic [1:0]                    occ_q, occ_d;
    logic                          issue_vld_q, issue_vld_d;
    logic [ELEM_W-1:0]             issue_elem_q, issue_elem_d;
    logic                          done_q, done_d;

    logic                          tag_vld_q [BRAM_LATENCY];
    logic [ELEM_W-1:0]             tag_idx_q [BRAM_LATENCY];

    logic [1:0]                    buf_full;
    logic [1:0]                    buf_wr;
    logic [1:0]                    buf_clr;
    logic [ROW_W-1:0]              buf_row [2];

    logic hs, elem_last, row_last, buf_free, can_issue;
    logic ret_vld, ret_last;
    logic [ELEM_W-1:0] ret_idx;

    assign m_valid_o = buf_full[send_buf_q];
    assign hs        = m_valid_o && m_ready_i;
    assign elem_last = (elem_cnt_q == ELEM_W'(NUM_FEATURE_OUT - 1));
    assign row_last  = (row_cnt_q == NODE_IDX_W'(NUM_SUBGRAPHS - 1));

    // A new row may claim the issue buffer if it is idle or is being handed
    // off this very cycle; that keeps back-to-back rows bubble-free.
    assign buf_free  = !occ_q[iss_buf_q] || (hs && (send_buf_q == iss_buf_q));
    assign can_issue = (state_q == ST_RUN) && ((elem_cnt_q != '0) || buf_free);

    assign ret_vld  = tag_vld_q[BRAM_LATENCY-1];
    assign ret_idx  = tag_idx_q[BRAM_LATENCY-1];
    assign ret_last = (ret_idx == ELEM_W'(NUM_FEATURE_OUT - 1));

    assign buf_wr[0]  = ret_vld && !ret_buf_q;
    assign buf_wr[1]  = ret_vld &&  ret_buf_q;
    assign buf_clr[0] = hs && !send_buf_q;
    assign buf_clr[1] = hs &&  send_buf_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        next_addr_d  = next_addr_q;
        elem_cnt_d   = elem_cnt_q;
        row_cnt_d    = row_cnt_q;
        iss_buf_d    = iss_buf_q;
        ret_buf_d    = ret_buf_q;
        send_buf_d   = send_buf_q;
        send_node_d  = send_node_q;
        occ_d        = occ_q;
        issue_vld_d  = 1'b0;
        issue_elem_d = issue_elem_q;
        done_d       = 1'b0;

        // Release before claim so a same-cycle hand-off leaves the buffer taken.
        if (hs) begin
            occ_d[send_buf_q] = 1'b0;
            send_buf_d        = ~send_buf_q;
            send_node_d       = m_last_o ? '0 : send_node_q + NODE_IDX_W'(1);
        end
        if (ret_vld && ret_last) ret_buf_d = ~ret_buf_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_RUN;
                    next_addr_d = '0;
                    elem_cnt_d  = '0;
                    row_cnt_d   = '0;
                    iss_buf_d   = 1'b0;
                    ret_buf_d   = 1'b0;
                    send_buf_d  = 1'b0;
                    send_node_d = '0;
                    occ_d       = '0;
                end
            end
            ST_RUN: begin
                if (can_issue) begin
                    addr_d       = next_addr_q;
                    next_addr_d  = next_addr_q + NEW_FEATURE_ADDR_W'(1);
                    issue_vld_d  = 1'b1;
                    issue_elem_d = elem_cnt_q;
                    if (elem_cnt_q == '0) occ_d[iss_buf_q] = 1'b1;
                    if (elem_last) begin
                        elem_cnt_d = '0;
                        iss_buf_d  = ~iss_buf_q;
                        if (row_last) begin
                            row_cnt_d = '0;
                            state_d   = ST_FLUSH;
                        end else begin
                            row_cnt_d = row_cnt_q + NODE_IDX_W'(1);
                        end
                    end else begin
                        elem_cnt_d = elem_cnt_q + ELEM_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (hs && m_last_o) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            next_addr_q  <= '0;
            elem_cnt_q   <= '0;
            row_cnt_q    <= '0;
            iss_buf_q    <= 1'b0;
            ret_buf_q    <= 1'b0;
            send_buf_q   <= 1'b0;
            send_node_q  <= '0;
            occ_q        <= '0;
            issue_vld_q  <= 1'b0;
            issue_elem_q <= '0;
            done_q       <= 1'b0;
            for (int unsigned i = 0; i < BRAM_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            next_addr_q  <= next_addr_d;
            elem_cnt_q   <= elem_cnt_d;
            row_cnt_q    <= row_cnt_d;
            iss_buf_q    <= iss_buf_d;
            ret_buf_q    <= ret_buf_d;
            send_buf_q   <= send_buf_d;
            send_node_q  <= send_node_d;
            occ_q        <= occ_d;
            issue_vld_q  <= issue_vld_d;
            issue_elem_q <= issue_elem_d;
            done_q       <= done_d;
            // The issue register is the address stage; the pipe then lines the
            // tag up with feat_bram_dout BRAM_LATENCY cycles later.
            tag_vld_q[0] <= issue_vld_q;
            tag_idx_q[0] <= issue_elem_q;
            for (int unsigned i = 1; i < BRAM_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

`ifdef FEAT_ARGMAX_EN
    logic [ELEM_W-1:0] buf_class [2];
`endif

    feat_row_buffer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .NUM_FEATURE_OUT (NUM_FEATURE_OUT)
    ) u_buf0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (buf_wr[0]),
        .wr_idx_i  (ret_idx),
        .wr_data_i (feat_bram_dout),
        .clr_i     (buf_clr[0]),
        .full_o    (buf_full[0]),
        .row_o     (buf_row[0])
`ifdef FEAT_ARGMAX_EN
        ,
        .class_o   (buf_class[0])
`endif
    );

    feat_row_buffer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .NUM_FEATURE_OUT (NUM_FEATURE_OUT)
    ) u_buf1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (buf_wr[1]),
        .wr_idx_i  (ret_idx),
        .wr_data_i (feat_bram_dout),
        .clr_i     (buf_clr[1]),
        .full_o    (buf_full[1]),
        .row_o     (buf_row[1])
`ifdef FEAT_ARGMAX_EN
        ,
        .class_o   (buf_class[1])
`endif
    );

    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
    assign feat_bram_addrb = addr_q;
    assign m_data_o        = buf_row[send_buf_q];
    assign m_node_o        = send_node_q;
    assign m_last_o        = m_valid_o && (send_node_q == NODE_IDX_W'(NUM_SUBGRAPHS - 1));
`ifdef FEAT_ARGMAX_EN
    assign m_class_o       = buf_class[send_buf_q];
`endif

endmodule
